alu_issue_decoder: RTL and testbench

//  Decode/issue stage that produces the 4-bit ALU opcode and both 32-bit ALU operands from an RV32I

---
 rtl/alu_issue_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_issue_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_decoder.sv
// rtl/alu_issue_decoder.sv - RV32I OP/OP-IMM/LUI/AUIPC decode-issue stage with registered ALU bundle
// Optional ALU_DECODE_SKID_EN: 2-entry skid buffer with registered in_ready.
module alu_issue_decoder #(
    parameter int XLEN     = 32,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_rs1_data,
    input  logic [XLEN-1:0]     in_rs2_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_alu_a,
    output logic [XLEN-1:0]     out_alu_b,
    output logic [OP_WIDTH-1:0] out_alu_op,
    output logic [4:0]          out_rd,
    output logic                out_wb_en,
    output logic                out_illegal,
    output logic [XLEN-1:0]     out_pc
);

    typedef struct packed {
        logic [XLEN-1:0]     alu_a;
        logic [XLEN-1:0]     alu_b;
        logic [OP_WIDTH-1:0] alu_op;
        logic [4:0]          rd;
        logic                wb_en;
        logic                illegal;
        logic [XLEN-1:0]     pc;
    } bundle_t;

    localparam logic [OP_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_WIDTH-1:0] ALU_SLL  = 4'd2;
    localparam logic [OP_WIDTH-1:0] ALU_SLT  = 4'd3;
    localparam logic [OP_WIDTH-1:0] ALU_SLTU = 4'd4;
    localparam logic [OP_WIDTH-1:0] ALU_XOR  = 4'd5;
    localparam logic [OP_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_WIDTH-1:0] ALU_OR   = 4'd8;
    localparam logic [OP_WIDTH-1:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    bundle_t             dec;
    logic [6:0]          opcode;
    logic [6:0]          funct7;
    logic [2:0]          funct3;
    logic [OP_WIDTH-1:0] base_op;
    logic [OP_WIDTH-1:0] op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic                legal;
    logic                accept;
    logic                out_xfer;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        base_op = ALU_ADD;
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        a     = '0;
        b     = '0;
        case (opcode)
            OPC_OP: begin
                a = in_rs1_data;
                b = in_rs2_data;
                if (funct7 == F7_ZERO) begin
                    legal = 1'b1;
                    op    = base_op;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal = 1'b1;
                    op    = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal = 1'b1;
                    op    = ALU_SRA;
                end
            end
            OPC_OPIMM: begin
                a     = in_rs1_data;
                b     = {{20{in_instr[31]}}, in_instr[31:20]};
                legal = 1'b1;
                op    = base_op;
                // Shift-immediates carry shamt in imm[4:0]; the upper imm bits act as funct7.
                if (funct3 == 3'b001) begin
                    b     = {27'b0, in_instr[24:20]};
                    legal = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    b = {27'b0, in_instr[24:20]};
                    if (funct7 == F7_ALT) begin
                        op = ALU_SRA;
                    end else begin
                        legal = (funct7 == F7_ZERO);
                    end
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                b     = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a     = in_pc;
                b     = {in_instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.alu_a   = legal ? a : '0;
        dec.alu_b   = legal ? b : '0;
        dec.alu_op  = legal ? op : ALU_ADD;
        dec.rd      = in_instr[11:7];
        dec.wb_en   = legal && (in_instr[11:7] != 5'd0);
        dec.illegal = !legal;
        dec.pc      = in_pc;
    end

    bundle_t head;

`ifdef ALU_DECODE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t  state;
    state_t  state_next;
    bundle_t tail;

    // in_ready depends only on the registered occupancy, never on out_ready.
    assign in_ready  = rst_n && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_next = ONE;
                ONE: begin
                    if (accept && !out_xfer) state_next = TWO;
                    else if (!accept && out_xfer) state_next = EMPTY;
                end
                TWO:     if (out_xfer) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: if (accept) head <= dec;
                ONE: begin
                    if (accept && out_xfer) head <= dec;
                    else if (accept) tail <= dec;
                end
                TWO:   if (out_xfer) head <= tail;
                default: ;
            endcase
        end
    end
`else
    logic valid_q;

    assign in_ready  = rst_n && (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign accept    = in_valid && in_ready && !flush;
    assign out_xfer  = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            head    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            head    <= dec;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end
`endif

    assign out_alu_a   = head.alu_a;
    assign out_alu_b   = head.alu_b;
    assign out_alu_op  = head.alu_op;
    assign out_rd      = head.rd;
    assign out_wb_en   = head.wb_en;
    assign out_illegal = head.illegal;
    assign out_pc      = head.pc;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// tb/tb_alu_issue_decoder.sv - randomized bench for alu_issue_decoder against a queue-based reference model
module tb_alu_issue_decoder;

`ifdef ALU_DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_a;
    logic [31:0] out_alu_b;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_illegal;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    alu_issue_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
        .out_alu_op(out_alu_op), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   f3_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [6:0] opc = instr[6:0];
        logic [6:0] f7  = instr[31:25];
        int         f3  = int'(instr[14:12]);
        int         imm = $signed(instr[31:20]);
        bit         ok  = 1'b0;
        logic [31:0] a  = 32'd0;
        logic [31:0] b  = 32'd0;
        int         op  = 0;
        if (opc == 7'h33) begin
            a = r1;
            b = r2;
            if (f7 == 7'h00) begin
                ok = 1'b1;
                op = f3_op[f3];
            end else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
                ok = 1'b1;
                op = (f3 == 0) ? 1 : 7;
            end
        end else if (opc == 7'h13) begin
            a = r1;
            if (f3 == 1 || f3 == 5) begin
                b  = 32'(instr[24:20]);
                ok = (f7 == 7'h00) || (f3 == 5 && f7 == 7'h20);
                op = (f7 == 7'h20) ? 7 : f3_op[f3];
            end else begin
                b  = 32'(imm);
                ok = 1'b1;
                op = f3_op[f3];
            end
        end else if (opc == 7'h37) begin
            ok = 1'b1;
            b  = instr & 32'hFFFF_F000;
        end else if (opc == 7'h17) begin
            ok = 1'b1;
            a  = pc;
            b  = instr & 32'hFFFF_F000;
        end
        if (!ok) begin
            a  = 32'd0;
            b  = 32'd0;
            op = 0;
        end
        e.a   = a;
        e.b   = b;
        e.op  = 4'(op);
        e.rd  = instr[11:7];
        e.wb  = ok && (instr[11:7] != 5'd0);
        e.ill = !ok;
        e.pc  = pc;
        return e;
    endfunction

    task automatic check_out(input bit after_rst);
        exp_t e;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("alu_a", out_alu_a, e.a);
            check("alu_b", out_alu_b, e.b);
            check("alu_op", 32'(out_alu_op), 32'(e.op));
            check("rd", 32'(out_rd), 32'(e.rd));
            check("wb_en", 32'(out_wb_en), 32'(e.wb));
            check("illegal", 32'(out_illegal), 32'(e.ill));
            check("pc", out_pc, e.pc);
        end else if (after_rst) begin
            check("rst_zero", out_alu_a | out_alu_b | out_pc | 32'(out_alu_op) | 32'(out_rd)
                  | 32'(out_wb_en) | 32'(out_illegal), 32'd0);
        end
    endtask

    // Called at a falling edge: drive, check in_ready, advance the model, sample after the next rise.
    task automatic step(input bit rs, input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2, input bit ordy, input bit fl);
        bit pred;
        rst_n = rs; in_valid = v; in_instr = ins; in_pc = pc;
        in_rs1_data = r1; in_rs2_data = r2; out_ready = ordy; flush = fl;
        #1;
        pred = rs && (SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy));
        check("in_ready", 32'(in_ready), 32'(pred));
        if (!rs || fl) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            if (v && pred) exp_q.push_back(ref_dec(ins, pc, r1, r2));
        end
        @(negedge clk);
        check_out(!rs);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom();
        logic [6:0]  opc;
        logic [6:0]  f7;
        case ($urandom_range(0, 5))
            0:       opc = 7'h33;
            1, 5:    opc = 7'h13;
            2:       opc = 7'h37;
            3:       opc = 7'h17;
            default: opc = r[6:0];
        endcase
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = r[31:25];
        endcase
        return {f7, r[24:7], opc};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        in_rs1_data = '0; in_rs2_data = '0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        step(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        step(0, 1, 32'h00500093, 32'h0, 32'h0, 32'h0, 1, 0);

        step(1, 1, 32'h00500093, 32'h100, 32'd0, 32'd9, 1, 0);
        check("addi_op", 32'(out_alu_op), 32'd0);
        check("addi_b", out_alu_b, 32'd5);
        check("addi_wb", 32'(out_wb_en), 32'd1);
        step(1, 1, 32'h402081B3, 32'h104, 32'd10, 32'd3, 1, 0);
        check("sub_op", 32'(out_alu_op), 32'd1);
        check("sub_a", out_alu_a, 32'd10);
        check("sub_b", out_alu_b, 32'd3);
        step(1, 1, 32'h4030D093, 32'h108, 32'hF000_0000, 32'd0, 1, 0);
        check("srai_op", 32'(out_alu_op), 32'd7);
        check("srai_b", out_alu_b, 32'd3);
        step(1, 1, 32'h123452B7, 32'h10C, 32'd7, 32'd7, 1, 0);
        check("lui_a", out_alu_a, 32'd0);
        check("lui_b", out_alu_b, 32'h12345000);
        step(1, 1, 32'h00000000, 32'h110, 32'd1, 32'd2, 1, 0);
        check("zero_ill", 32'(out_illegal), 32'd1);
        check("zero_wb", 32'(out_wb_en), 32'd0);
        check("zero_valid", 32'(out_valid), 32'd1);
        step(1, 1, 32'h00500013, 32'h114, 32'd4, 32'd0, 1, 0);
        check("rd0_wb", 32'(out_wb_en), 32'd0);

        for (int i = 0; i < 3; i++)
            step(1, 1, rand_instr(), 32'h200 + 32'(4 * i), $urandom(), $urandom(), 0, 0);
        check("hold_rdy", 32'(in_ready), 32'd0);
        step(1, 1, 32'h00500093, 32'h300, 32'd1, 32'd1, 0, 1);
        check("flush_valid", 32'(out_valid), 32'd0);
        step(1, 1, 32'h402081B3, 32'h304, 32'd5, 32'd6, 0, 0);
        step(0, 1, 32'h00500093, 32'h308, 32'd1, 32'd1, 0, 0);
        check("rst_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, rand_instr(), $urandom(),
                 $urandom(), $urandom(), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
